// File: rtl/operand_sequencer_pkg.sv
// Shared state encodings and default datapath width for the adder front end.
package operand_sequencer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HAVE_A = 2'd1,
    S_SETTLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/operand_sequencer_key_pulse.sv
// Turns the asynchronous Load key level into a single-cycle pulse.
// The pulse registers on the 3rd Clock edge after Load rises.
module key_pulse (
  input  logic Clock,
  input  logic Resetn,
  input  logic Load,
  output logic ld_p
);

  logic sync1;
  logic sync2;
  logic sync2_d;
  logic primed;
  logic armed;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
      primed  <= 1'b0;
      armed   <= 1'b0;
      ld_p    <= 1'b0;
    end else begin
      sync1   <= Load;
      sync2   <= sync1;
      sync2_d <= sync2;
      primed  <= 1'b1;
      // Only a genuinely sampled low arms the detector, so a key held through reset stays silent.
      if (primed && !sync1) begin
        armed <= 1'b1;
      end
      ld_p    <= sync2 && !sync2_d && armed;
    end
  end

endmodule

// File: rtl/operand_sequencer.sv
// Captures A then B on Load presses, drives the shared adder, and after a settle delay
// registers {Cout, S} plus signed overflow for display.
module operand_sequencer
  import operand_sequencer_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [WIDTH-1:0] Din,
  input  logic             Sub,
  input  logic             Load,
  output logic [WIDTH-1:0] Adder_A,
  output logic [WIDTH-1:0] Adder_B,
  output logic             Adder_Cin,
  input  logic [WIDTH-1:0] Adder_S,
  input  logic             Adder_Cout,
  output logic [WIDTH:0]   Result,
  output logic             Ovf,
  output logic             Valid,
  output logic [1:0]       State
);

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t           st;
  logic [WIDTH-1:0] reg_a;
  logic [WIDTH-1:0] reg_b;
  logic             sub_r;
  logic [3:0]       cnt;
  logic             ld_p;
  logic             ovf_c;

  key_pulse u_key_pulse (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Load   (Load),
    .ld_p   (ld_p)
  );

  // Subtraction reuses the adder as A + ~B + 1; Cout is passed through raw (1 = no borrow).
  assign Adder_A   = reg_a;
  assign Adder_B   = sub_r ? ~reg_b : reg_b;
  assign Adder_Cin = sub_r;
  assign State     = st;

  assign ovf_c = (reg_a[WIDTH-1] == Adder_B[WIDTH-1]) && (Adder_S[WIDTH-1] != reg_a[WIDTH-1]);

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      st     <= S_IDLE;
      reg_a  <= '0;
      reg_b  <= '0;
      sub_r  <= 1'b0;
      cnt    <= 4'd0;
      Result <= '0;
      Ovf    <= 1'b0;
      Valid  <= 1'b0;
    end else begin
      case (st)
        S_IDLE: begin
          if (ld_p) begin
            reg_a <= Din;
            st    <= S_HAVE_A;
          end
        end
        S_HAVE_A: begin
          if (ld_p) begin
            reg_b <= Din;
            sub_r <= Sub;
            cnt   <= CNT_INIT;
            st    <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          // Key presses here are dropped on purpose; the operation in flight must finish.
          if (cnt == 4'd0) begin
            Result <= {Adder_Cout, Adder_S};
            Ovf    <= ovf_c;
            Valid  <= 1'b1;
            st     <= S_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE: begin
          if (ld_p) begin
            reg_a <= Din;
            Valid <= 1'b0;
            st    <= S_HAVE_A;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench with a behavioural 4-bit adder and a result scoreboard.
module tb_operand_sequencer;

  localparam int W  = 4;
  localparam int SC = 6;

  logic         Clock = 1'b0;
  logic         Resetn;
  logic [W-1:0] Din;
  logic         Sub;
  logic         Load;
  logic [W-1:0] Adder_A;
  logic [W-1:0] Adder_B;
  logic         Adder_Cin;
  logic [W-1:0] Adder_S;
  logic         Adder_Cout;
  logic [W:0]   Result;
  logic         Ovf;
  logic         Valid;
  logic [1:0]   State;

  int n_chk  = 0;
  int n_fail = 0;
  logic [5:0] exp_q[$];

  always #5 Clock = ~Clock;

  assign {Adder_Cout, Adder_S} = {1'b0, Adder_A} + {1'b0, Adder_B} + {4'b0000, Adder_Cin};

  operand_sequencer #(.WIDTH(W), .SETTLE_CYCLES(SC)) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .Din        (Din),
    .Sub        (Sub),
    .Load       (Load),
    .Adder_A    (Adder_A),
    .Adder_B    (Adder_B),
    .Adder_Cin  (Adder_Cin),
    .Adder_S    (Adder_S),
    .Adder_Cout (Adder_Cout),
    .Result     (Result),
    .Ovf        (Ovf),
    .Valid      (Valid),
    .State      (State)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every rising Valid consumes one expected {Result, Ovf}.
  logic prev_v = 1'b0;
  always @(negedge Clock) begin
    logic [5:0] e;
    if (Valid === 1'b1 && prev_v !== 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid: got Result=%b with empty scoreboard", Result);
      end else begin
        e = exp_q.pop_front();
        check("result", Result, e[5:1]);
        check("ovf", Ovf, e[0]);
      end
    end
    prev_v = Valid;
  end

  task automatic load_op(input logic [3:0] d, input logic s, input logic [1:0] exp_st,
                         input bit chk_settle);
    int  n;
    bit  seen;
    Load = 1'b0;
    repeat (3) @(negedge Clock);
    Din  = d;
    Sub  = s;
    Load = 1'b1;
    n    = 0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge Clock);
      n++;
      if (State == exp_st) seen = 1'b1;
    end
    check("capture_state", State, exp_st);
    check("ld_latency", n, 4);
    Load = 1'b0;
    Din  = ~d;
    Sub  = ~s;
    if (chk_settle) begin
      n    = 0;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
        @(negedge Clock);
        n++;
        if (Valid) seen = 1'b1;
      end
      check("settle_edges", n, SC);
      check("done_state", State, 2'd3);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_adder_a", Adder_A, 0);
    check("rst_adder_b", Adder_B, 0);
    check("rst_adder_cin", Adder_Cin, 0);
    check("rst_result", Result, 0);
    check("rst_ovf", Ovf, 0);
    check("rst_valid", Valid, 0);
    check("rst_state", State, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    Resetn = 1'b0;
    Din    = '0;
    Sub    = 1'b0;
    Load   = 1'b0;
    repeat (3) @(negedge Clock);
    Resetn = 1'b1;
    check_reset_outputs();

    // 5 + 3 overflows signed 4-bit
    load_op(4'b0101, 1'b0, 2'd1, 1'b0);
    exp_q.push_back({5'b01000, 1'b1});
    load_op(4'b0011, 1'b0, 2'd2, 1'b1);

    // 5 - 3: no borrow
    load_op(4'b0101, 1'b0, 2'd1, 1'b0);
    check("valid_drop", Valid, 0);
    exp_q.push_back({5'b10010, 1'b0});
    load_op(4'b0011, 1'b1, 2'd2, 1'b1);
    check("sub_adder_b", Adder_B, 4'b1100);
    check("sub_adder_cin", Adder_Cin, 1);

    // 3 - 5: borrow, S = -2
    load_op(4'b0011, 1'b0, 2'd1, 1'b0);
    exp_q.push_back({5'b01110, 1'b0});
    load_op(4'b0101, 1'b1, 2'd2, 1'b1);

    // Back to IDLE, then hold Load for 20 cycles
    @(negedge Clock);
    Resetn = 1'b0;
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    check("idle_after_reset", State, 0);
    repeat (3) @(negedge Clock);
    Din  = 4'b0110;
    Load = 1'b1;
    repeat (20) @(negedge Clock);
    check("hold_single_capture", State, 1);
    check("hold_adder_a", Adder_A, 4'b0110);

    // Load pulse during SETTLE must be ignored
    exp_q.push_back({5'b00111, 1'b0});
    load_op(4'b0001, 1'b0, 2'd2, 1'b0);
    @(negedge Clock);
    Load = 1'b1;
    @(negedge Clock);
    Load = 1'b0;
    for (int i = 0; i < 20 && !Valid; i++) @(negedge Clock);
    check("ignore_done", State, 3);
    repeat (8) @(negedge Clock);
    check("ignore_not_queued", State, 3);

    // New A from DONE: Valid drops, Result holds
    load_op(4'b1001, 1'b0, 2'd1, 1'b0);
    check("done_valid_drop", Valid, 0);
    check("done_result_hold", Result, 5'b00111);
    exp_q.push_back({5'b01011, 1'b0});
    load_op(4'b0010, 1'b0, 2'd2, 1'b1);

    // Reset mid-SETTLE with Load held through reset
    load_op(4'b0100, 1'b0, 2'd1, 1'b0);
    load_op(4'b0100, 1'b0, 2'd2, 1'b0);
    Load   = 1'b1;
    Resetn = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
    check_reset_outputs();
    repeat (8) @(negedge Clock);
    check("held_load_no_pulse", State, 0);

    load_op(4'b0010, 1'b0, 2'd1, 1'b0);
    exp_q.push_back({5'b00011, 1'b0});
    load_op(4'b0001, 1'b0, 2'd2, 1'b1);

    repeat (4) @(negedge Clock);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
